udp_rx_port_demux: RTL
======================

UDP_RX_PORT_DEMUX -- requirements
Module: udp_rx_port_demux

Interface
REQ-001 Parameter N_CH, default 4: number of output channels, range 1..8.
REQ-002 Parameter PORT_BASE, default 16'd5000: channel i owns UDP destination port PORT_BASE+i.
REQ-003 Parameter LEN_W, default 16: payload length counter width.
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 s_tdata  in  8  UDP datagram byte stream, header first, from the IP receive block.
REQ-006 s_tvalid / s_tlast  in  1 / 1  AXIS valid and end of datagram; s_tready  out  1  AXIS ready.
REQ-007 m_tdata  out  8  payload byte, shared by all channels.
REQ-008 m_tvalid  out  N_CH  one-hot valid; m_tlast  out  1  last payload byte.
REQ-009 m_tready  in  N_CH  per-channel ready; m_tuser  out  1  error marker, meaningful only with m_tlast.
REQ-010 src_port / dst_port / pay_len  out  16 each  header fields of the current datagram; held until the next header completes.
REQ-011 drop_cnt  out  16  saturating count of discarded datagrams; runt_cnt  out  16  saturating count of truncated datagrams.

Function
REQ-012 FSM states: HDR, PAY, TRIM, DROP.
REQ-013 HDR: s_tready=1; bytes 0-7 are captured big-endian as src_port, dst_port, length and checksum.
REQ-014 On header byte 7, the block computes pay_len = length-8 and selects ch = dst_port-PORT_BASE.
REQ-015 From HDR after byte 7: if length<9 or dst_port is outside [PORT_BASE, PORT_BASE+N_CH-1], go to DROP and increment drop_cnt; otherwise go to PAY.
REQ-016 PAY output stage: single register stage, latency 1 cycle; s_tready = !out_valid || m_tready[ch].
REQ-017 In PAY, the output register loads on s_tvalid&&s_tready; m_tvalid[ch] is the only valid bit set; the other channels stay 0.
REQ-018 In PAY, m_tdata/m_tlast/m_tuser stay stable while m_tvalid[ch]=1 and m_tready[ch]=0.
REQ-019 Payload byte counter counts up from 0; m_tlast=1 on byte pay_len-1 or on s_tlast, whichever comes first.
REQ-020 On the byte pay_len-1 without s_tlast, go to TRIM; TRIM has s_tready=1 and discards IP padding up to s_tlast, then goes to HDR.
REQ-021 If s_tlast arrives before byte pay_len-1 (short datagram): m_tlast=1, m_tuser=1, increment runt_cnt, go to HDR.
REQ-022 If s_tlast arrives during HDR: increment runt_cnt, no output, stay in HDR, restart at byte 0.
REQ-023 DROP: s_tready=1; discard bytes until s_tlast, then go to HDR.
REQ-024 Counters saturate at 16'hFFFF.
REQ-025 A new header may be accepted on the cycle after the final payload byte is accepted, with no bubble on the input.

Reset
REQ-026 Reset effects:
- FSM = HDR.
- m_tvalid, m_tlast, m_tuser, m_tdata, all header outputs and both counters = 0.
- s_tready = 0 during reset, 1 in the first cycle after reset.
REQ-027 Reset mid-datagram abandons the datagram with no m_tlast; the remaining input bytes are treated as a new header.

Configuration
REQ-028 Macro UDP_RX_CSUM_EN defined: a ones-complement sum is accumulated over the pseudo-header-free UDP header and payload. On the final payload byte, m_tuser = 1 if checksum!=0 and the sum is not 16'hFFFF.
REQ-029 Macro UDP_RX_CSUM_EN undefined: there is no checksum logic, and m_tuser is set only per REQ-021.

Verification
REQ-030 Port 5001, length 12, payload 01 02 03 04, all ready=1 -> m_tvalid=4'b0010 for 4 cycles, data 01..04, m_tlast on 04, m_tuser=0.
REQ-031 Port 6000 (unmatched), length 20 -> no m_tvalid, s_tready=1 throughout, drop_cnt=1.
REQ-032 Port 5000, length 10, input carries 2 payload + 4 padding bytes, s_tlast on the last pad -> m_tlast on payload byte 2, pads discarded, next header accepted.
REQ-033 Port 5003, length 16, s_tlast after 3 payload bytes -> m_tlast=1 and m_tuser=1 on byte 3, runt_cnt=1.
REQ-034 Port 5002, 6-byte payload, m_tready[2] low for 5 cycles mid-payload -> outputs held stable, no byte lost or duplicated, s_tready low while stalled.
REQ-035 With UDP_RX_CSUM_EN defined, a datagram with a corrupted payload byte and a nonzero checksum -> m_tuser=1 on m_tlast; the same datagram with checksum=0 -> m_tuser=0.

Source files
------------

// File: rtl/udp_rx_port_demux.sv
// udp_rx_port_demux: strips the UDP header from a received datagram and steers its payload to one of N_CH channels by destination port.
// Optional feature: define UDP_RX_CSUM_EN to add ones-complement checksum verification (flagged on m_tuser with m_tlast).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready   input byte stream, header first
//   m_tdata/m_tvalid/m_tlast/m_tuser    payload stream, one-hot valid per channel, m_tuser = error with m_tlast
//   m_tready              per-channel ready
//   src_port/dst_port/pay_len   header fields of the last completed header
//   drop_cnt/runt_cnt     saturating counts of discarded and truncated datagrams
module udp_rx_port_demux #(
    parameter int          N_CH      = 4,
    parameter logic [15:0] PORT_BASE = 16'd5000,
    parameter int          LEN_W     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      s_tdata,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    output logic            s_tready,
    output logic [7:0]      m_tdata,
    output logic [N_CH-1:0] m_tvalid,
    output logic            m_tlast,
    output logic            m_tuser,
    input  logic [N_CH-1:0] m_tready,
    output logic [15:0]     src_port,
    output logic [15:0]     dst_port,
    output logic [15:0]     pay_len,
    output logic [15:0]     drop_cnt,
    output logic [15:0]     runt_cnt
);
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    typedef enum logic [1:0] {HDR, PAY, TRIM, DROP} state_t;
    state_t           state;
    logic [2:0]       hdr_idx;
    logic [47:0]      hdr_sr;
    logic [LEN_W-1:0] pay_cnt, last_idx;
    logic [CH_W-1:0]  ch, out_ch;
    logic             out_valid, acc, is_last_pay, hdr_ok, csum_err;
    logic [15:0]      dst_in, len_in;
    logic [16:0]      off;
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return c + {15'd0, c != 16'hFFFF};
    endfunction
    // Stall only on the channel whose byte is still waiting in the output register.
    assign s_tready    = reset ? 1'b0 : state == PAY ? (!out_valid || m_tready[out_ch]) : 1'b1;
    assign acc         = s_tvalid && s_tready;
    // At header byte 7 the shift register holds bytes 0..5: src, dst, length.
    assign dst_in      = hdr_sr[31:16];
    assign len_in      = hdr_sr[15:0];
    assign off         = {1'b0, dst_in} - {1'b0, PORT_BASE};
    assign hdr_ok      = len_in >= 16'd9 && !off[16] && off < 17'(N_CH);
    assign is_last_pay = pay_cnt == last_idx;
    always_comb begin
        m_tvalid = '0;
        for (int i = 0; i < N_CH; i++) m_tvalid[i] = out_valid && out_ch == CH_W'(i);
    end
`ifdef UDP_RX_CSUM_EN
    logic [15:0] csum_acc, csum_word, csum_next;
    logic [7:0]  ck_hi;
    logic        ck_nz;
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction
    // Even byte positions are the high half of a 16-bit word; payload starts at an even offset.
    assign csum_word = (state == HDR ? hdr_idx[0] : pay_cnt[0]) ? {8'h00, s_tdata} : {s_tdata, 8'h00};
    assign csum_next = oc_add(state == HDR && hdr_idx == 3'd0 ? 16'h0000 : csum_acc, csum_word);
    assign csum_err  = is_last_pay && ck_nz && csum_next != 16'hFFFF;
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_acc <= '0;
            ck_hi    <= '0;
            ck_nz    <= 1'b0;
        end else if (acc && (state == HDR || state == PAY)) begin
            csum_acc <= csum_next;
            if (state == HDR && hdr_idx == 3'd6) ck_hi <= s_tdata;
            if (state == HDR && hdr_idx == 3'd7) ck_nz <= {ck_hi, s_tdata} != 16'h0000;
        end
    end
`else
    assign csum_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HDR;
            hdr_idx   <= '0;
            hdr_sr    <= '0;
            pay_cnt   <= '0;
            last_idx  <= '0;
            ch        <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            m_tuser   <= 1'b0;
            src_port  <= '0;
            dst_port  <= '0;
            pay_len   <= '0;
            drop_cnt  <= '0;
            runt_cnt  <= '0;
        end else begin
            if (out_valid && m_tready[out_ch]) out_valid <= 1'b0;
            if (acc) begin
                case (state)
                    HDR: begin
                        if (s_tlast) begin
                            hdr_idx  <= '0;
                            runt_cnt <= sat_inc(runt_cnt);
                        end else if (hdr_idx == 3'd7) begin
                            hdr_idx  <= '0;
                            src_port <= hdr_sr[47:32];
                            dst_port <= dst_in;
                            pay_len  <= len_in - 16'd8;
                            last_idx <= LEN_W'(len_in - 16'd9);
                            ch       <= CH_W'(off);
                            pay_cnt  <= '0;
                            state    <= hdr_ok ? PAY : DROP;
                            if (!hdr_ok) drop_cnt <= sat_inc(drop_cnt);
                        end else begin
                            hdr_idx <= hdr_idx + 3'd1;
                            if (hdr_idx < 3'd6) hdr_sr <= {hdr_sr[39:0], s_tdata};
                        end
                    end
                    PAY: begin
                        out_valid <= 1'b1;
                        out_ch    <= ch;
                        m_tdata   <= s_tdata;
                        m_tlast   <= is_last_pay || s_tlast;
                        m_tuser   <= (s_tlast && !is_last_pay) || csum_err;
                        pay_cnt   <= pay_cnt + LEN_W'(1);
                        if (s_tlast && !is_last_pay) runt_cnt <= sat_inc(runt_cnt);
                        state <= s_tlast ? HDR : is_last_pay ? TRIM : PAY;
                    end
                    default: if (s_tlast) state <= HDR;
                endcase
            end
        end
    end
endmodule
